// File: rtl/sc_backg_lane_datapath_if.sv
// sc_backg_lane_datapath_if: command/status bundle between the background state machine and one lane datapath (SC_BACKG_SHIFTCOUNT_EN adds the rotate counter).
interface sc_backg_lane_datapath_if #(parameter int DATAWIDTH = 8);
  logic                 SC_BACKGLANE_clear_InLow;
  logic                 SC_BACKGLANE_load_InLow;
  logic [1:0]           SC_BACKGLANE_shiftselection_InBus;
  logic                 SC_BACKGLANE_upcount_InLow;
  logic [DATAWIDTH-1:0] SC_BACKGLANE_data_InBus;
  logic [DATAWIDTH-1:0] SC_BACKGLANE_lane_OutBus;
  logic                 SC_BACKGLANE_T0_OutLow;
`ifdef SC_BACKG_SHIFTCOUNT_EN
  logic [3:0]           SC_BACKGLANE_shiftcount_OutBus;
`endif
  modport master (
    output SC_BACKGLANE_clear_InLow, SC_BACKGLANE_load_InLow, SC_BACKGLANE_shiftselection_InBus,
           SC_BACKGLANE_upcount_InLow, SC_BACKGLANE_data_InBus,
    input  SC_BACKGLANE_lane_OutBus, SC_BACKGLANE_T0_OutLow
`ifdef SC_BACKG_SHIFTCOUNT_EN
    , input SC_BACKGLANE_shiftcount_OutBus
`endif
  );
  modport slave (
    input  SC_BACKGLANE_clear_InLow, SC_BACKGLANE_load_InLow, SC_BACKGLANE_shiftselection_InBus,
           SC_BACKGLANE_upcount_InLow, SC_BACKGLANE_data_InBus,
    output SC_BACKGLANE_lane_OutBus, SC_BACKGLANE_T0_OutLow
`ifdef SC_BACKG_SHIFTCOUNT_EN
    , output SC_BACKGLANE_shiftcount_OutBus
`endif
  );
endinterface

// File: rtl/sc_backg_lane_datapath.sv
// sc_backg_lane_datapath: background lane rotate register plus pacing timer with terminal flag T0.
// Optional SC_BACKG_SHIFTCOUNT_EN adds a saturating count of applied rotates.
module sc_backg_lane_datapath #(
  parameter int                   DATAWIDTH    = 8,
  parameter int                   COUNT_WIDTH  = 22,
  parameter int                   TICK_LIMIT   = 2500000,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = 8'b11000011
) (
  input logic SC_STATEMACHINEBACKG_CLOCK_50,
  input logic SC_STATEMACHINEBACKG_RESET_InHigh,
  sc_backg_lane_datapath_if.slave lane_if
);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(TICK_LIMIT - 1);
  logic [DATAWIDTH-1:0]   lane, lane_nxt;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic                   clr, ld, up, rot_l, rot_r;
  always_comb begin
    clr       = !lane_if.SC_BACKGLANE_clear_InLow;
    ld        = !lane_if.SC_BACKGLANE_load_InLow;
    up        = !lane_if.SC_BACKGLANE_upcount_InLow;
    rot_l     = lane_if.SC_BACKGLANE_shiftselection_InBus == 2'b10;
    rot_r     = lane_if.SC_BACKGLANE_shiftselection_InBus == 2'b01;
    lane_nxt  = clr ? INIT_PATTERN :
                ld  ? lane_if.SC_BACKGLANE_data_InBus :
                rot_l ? {lane[DATAWIDTH-2:0], lane[DATAWIDTH-1]} :
                rot_r ? {lane[0], lane[DATAWIDTH-1:1]} : lane;
    count_nxt = clr ? '0 :
                !up ? count :
                count == LAST ? '0 : count + COUNT_WIDTH'(1);
  end
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh)
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      lane  <= '0;
      count <= '0;
    end else begin
      lane  <= lane_nxt;
      count <= count_nxt;
    end
  // T0 decodes the registered count only, so command inputs cannot glitch it
  assign lane_if.SC_BACKGLANE_lane_OutBus = lane;
  assign lane_if.SC_BACKGLANE_T0_OutLow   = count != LAST;
`ifdef SC_BACKG_SHIFTCOUNT_EN
  logic [3:0] shift_count;
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh)
    if (SC_STATEMACHINEBACKG_RESET_InHigh) shift_count <= '0;
    else shift_count <= clr ? 4'd0 :
                        (!ld && (rot_l || rot_r) && shift_count != 4'd15) ? shift_count + 4'd1 : shift_count;
  assign lane_if.SC_BACKGLANE_shiftcount_OutBus = shift_count;
`endif
endmodule

// File: doc/sc_backg_lane_datapath.md
Name: sc_backg_lane_datapath

Overview:
- Datapath and pacing timer for one background lane of the game field.
- Takes the command strobes from the background state machine: clear, load, shift selection and count enable.
- Returns the timer terminal-count flag T0 that the state machine polls.
- Holds the lane bit pattern that drives the display and collision logic, and rotates it once per timer period.

Parameters:
- DATAWIDTH, 8, lane register width in bits.
- COUNT_WIDTH, 22, pacing counter width in bits.
- TICK_LIMIT, 2500000, number of counted upcount strobes per period; must be >= 2 and <= 2^COUNT_WIDTH.
- INIT_PATTERN, 8'b11000011, lane pattern loaded on clear; width equals DATAWIDTH.

Ports:
- SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_STATEMACHINEBACKG_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_BACKGLANE_clear_InLow  in  1  low: reload INIT_PATTERN and zero the counter.
- SC_BACKGLANE_load_InLow  in  1  low: load SC_BACKGLANE_data_InBus into the lane.
- SC_BACKGLANE_shiftselection_InBus  in  2  11 = hold, 10 = rotate left, 01 = rotate right, 00 = hold (reserved).
- SC_BACKGLANE_upcount_InLow  in  1  low: advance the pacing counter by one.
- SC_BACKGLANE_data_InBus  in  DATAWIDTH  parallel load data.
- SC_BACKGLANE_lane_OutBus  out  DATAWIDTH  current lane register.
- SC_BACKGLANE_T0_OutLow  out  1  low while counter == TICK_LIMIT-1.

Behaviour:
- Reset: SC_STATEMACHINEBACKG_RESET_InHigh high asynchronously sets:
  - lane = 0
  - counter = 0
  - T0_OutLow = 1
  Release takes effect at the next rising edge. Reset mid-operation discards any pending command.
- Lane register: updates on the rising edge. Priority, highest first:
  1. clear_InLow = 0: lane <= INIT_PATTERN.
  2. load_InLow = 0: lane <= data_InBus.
  3. shiftselection = 10: lane <= {lane[DATAWIDTH-2:0], lane[DATAWIDTH-1]} (rotate left, MSB wraps into LSB).
  4. shiftselection = 01: lane <= {lane[0], lane[DATAWIDTH-1:1]} (rotate right).
  5. Otherwise: hold.
  - One rotate per cycle the selection is held. No bits are lost, so the pattern is preserved modulo rotation.
- Pacing counter:
  - clear_InLow = 0: counter <= 0. Clear wins over a simultaneous upcount.
  - Otherwise, upcount_InLow = 0: if counter == TICK_LIMIT-1, counter <= 0 (wrap); else counter <= counter+1.
  - upcount_InLow = 1: hold.
  - Load and shift commands do not affect the counter.
- T0_OutLow:
  - Combinational decode of the counter register only, never of the inputs: 0 iff counter == TICK_LIMIT-1, else 1.
  - Glitch-free with respect to the command inputs.
  - Stays low until the next counted upcount, which wraps the counter.
  - With the controller loop CHECK -> SHIFT -> COUNT, this gives exactly one rotate per TICK_LIMIT counted strobes: the COUNT state's strobe wraps the counter and releases T0.
- Simultaneous commands:
  - Clear + shift: lane = INIT_PATTERN, counter = 0.
  - Load + shift: lane = data.
  - Shift + upcount in the same cycle: both occur.
- Latency: every command takes effect one edge after it is sampled. T0 reflects the new count in the same cycle as the counter update.
- Counter arithmetic: unsigned COUNT_WIDTH bits, never exceeds TICK_LIMIT-1.

Optional Feature:
- Macro: SC_BACKG_SHIFTCOUNT_EN.
- Defined:
  - Adds output SC_BACKGLANE_shiftcount_OutBus, 4 bits: number of rotate operations (10 or 01 actually applied) since the last reset or clear.
  - Saturates at 15.
  - Reset value 0. clear_InLow = 0 forces 0. Load does not change it.
  - A rotate suppressed by clear or load is not counted.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset mid-run (counter = 2, lane = 8'hA5), assert reset asynchronously between edges -> lane = 8'h00, T0_OutLow = 1, counter = 0 immediately, before the next edge.
2. TICK_LIMIT = 4: clear low one cycle, then upcount low for 3 cycles -> lane = 8'hC3, T0_OutLow falls after the 3rd strobe. A 4th strobe wraps the counter to 0 and T0_OutLow returns to 1.
3. Load 8'b1000_0001, then shiftselection = 10 for one cycle -> 8'b0000_0011. Then 01 for two cycles -> 8'b1000_0001, then 8'b1100_0000.
4. Simultaneous: clear low + load low + shiftselection 10 + upcount low in one cycle, counter previously 3 -> lane = INIT_PATTERN, counter = 0, T0_OutLow = 1.
5. Closed loop with the background state machine, TICK_LIMIT = 4, startGame pulsed low then released -> lane = 8'hC3 after the INIT state, then exactly one left rotate per 4 COUNT visits: 8'h87, 8'h0F, ...
6. With SC_BACKG_SHIFTCOUNT_EN: 20 consecutive rotates -> shiftcount_OutBus saturates at 15. Then clear low -> 0. Rotate issued in the same cycle as load -> count unchanged.
